// File: rtl/tilelink_scratchpad_manager.sv
// -----------------------------------------------------------------------------
// tilelink_scratchpad_manager
//
// Manager-side TileLink endpoint backed by an on-chip scratchpad RAM of
// DEPTH_BLOCKS blocks, each holding 8 beats of 64 bits. It serves one
// transaction at a time and never issues probes.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   io_acquire_*      : client requests (Get, GetBlock, Put, PutBlock, non-builtin)
//   io_probe_*        : unused, driven to zero
//   io_release_*      : client releases; data-bearing types carry 8 beats
//   io_grant_*        : responses (read data, putAck, release ack)
//   io_finish_*       : finish handshake that closes a non-builtin acquire
//
// state         | meaning
// --------------+-------------------------------------------------------------
// S_IDLE        | ready for an acquire or a release (a release has priority)
// S_PUT_COLLECT | writing the remaining PutBlock beats until beat 7
// S_REL_COLLECT | writing the remaining release data beats until beat 7
// S_GRANT_DATA  | returning read data (one beat for Get, 8 beats for block reads)
// S_GRANT_ACK   | single data-less grant (putAck, or voluntary release ack)
// S_WAIT_FINISH | waiting for the finish of a non-builtin acquire
// -----------------------------------------------------------------------------
module tilelink_scratchpad_manager #(
  parameter int unsigned DEPTH_BLOCKS = 16,
  parameter bit          MANAGER_ID   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_acquire_ready,
  input  logic        io_acquire_valid,
  input  logic [25:0] io_acquire_bits_addr_block,
  input  logic [1:0]  io_acquire_bits_client_xact_id,
  input  logic [2:0]  io_acquire_bits_addr_beat,
  input  logic        io_acquire_bits_is_builtin_type,
  input  logic [2:0]  io_acquire_bits_a_type,
  input  logic [11:0] io_acquire_bits_union,
  input  logic [63:0] io_acquire_bits_data,
  input  logic        io_probe_ready,
  output logic        io_probe_valid,
  output logic [25:0] io_probe_bits_addr_block,
  output logic [1:0]  io_probe_bits_p_type,
  output logic        io_release_ready,
  input  logic        io_release_valid,
  input  logic [2:0]  io_release_bits_addr_beat,
  input  logic [25:0] io_release_bits_addr_block,
  input  logic [1:0]  io_release_bits_client_xact_id,
  input  logic        io_release_bits_voluntary,
  input  logic [2:0]  io_release_bits_r_type,
  input  logic [63:0] io_release_bits_data,
  input  logic        io_grant_ready,
  output logic        io_grant_valid,
  output logic [2:0]  io_grant_bits_addr_beat,
  output logic [1:0]  io_grant_bits_client_xact_id,
  output logic        io_grant_bits_manager_xact_id,
  output logic        io_grant_bits_is_builtin_type,
  output logic [3:0]  io_grant_bits_g_type,
  output logic [63:0] io_grant_bits_data,
  output logic        io_grant_bits_manager_id,
  output logic        io_finish_ready,
  input  logic        io_finish_valid,
  input  logic        io_finish_bits_manager_xact_id,
  input  logic        io_finish_bits_manager_id
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_BLOCKS);
  localparam int unsigned ADDR_W = IDX_W + 3;
  localparam int unsigned WORDS  = DEPTH_BLOCKS * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT_COLLECT,
    S_REL_COLLECT,
    S_GRANT_DATA,
    S_GRANT_ACK,
    S_WAIT_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         id_q, id_d;
  logic [IDX_W-1:0]   blk_q, blk_d;
  logic [2:0]         beat_q, beat_d;
  logic               builtin_q, builtin_d;
  logic               single_q, single_d;
  logic               vol_q, vol_d;
  logic [3:0]         ack_type_q, ack_type_d;

  logic [63:0]        ram_q [WORDS];

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [63:0]        wr_data;
  logic [7:0]         wr_mask;

  logic               acq_rdy, rel_rdy, fin_rdy, gnt_vld;
  logic [2:0]         gnt_beat;
  logic [1:0]         gnt_id;
  logic               gnt_builtin;
  logic [3:0]         gnt_type;
  logic [63:0]        gnt_data;

  logic [IDX_W-1:0]   acq_idx, rel_idx;
  logic [7:0]         acq_mask;
  logic               run;

  // Block index is the low address bits; higher bits alias.
  assign acq_idx  = io_acquire_bits_addr_block[IDX_W-1:0];
  assign rel_idx  = io_release_bits_addr_block[IDX_W-1:0];
  assign acq_mask = io_acquire_bits_union[8:1];
  assign run      = ~reset;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    blk_d       = blk_q;
    beat_d      = beat_q;
    builtin_d   = builtin_q;
    single_d    = single_q;
    vol_d       = vol_q;
    ack_type_d  = ack_type_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_mask     = '0;
    acq_rdy     = 1'b0;
    rel_rdy     = 1'b0;
    fin_rdy     = 1'b0;
    gnt_vld     = 1'b0;
    gnt_beat    = '0;
    gnt_id      = '0;
    gnt_builtin = 1'b0;
    gnt_type    = '0;
    gnt_data    = '0;

    case (state_q)
      S_IDLE: begin
        rel_rdy = 1'b1;
        acq_rdy = ~io_release_valid;
        if (io_release_valid) begin
          id_d  = io_release_bits_client_xact_id;
          blk_d = rel_idx;
          vol_d = io_release_bits_voluntary;
          if (io_release_bits_r_type <= 3'd2) begin
            wr_en   = 1'b1;
            wr_addr = {rel_idx, io_release_bits_addr_beat};
            wr_data = io_release_bits_data;
            wr_mask = 8'hFF;
            state_d = S_REL_COLLECT;
          end else if (io_release_bits_voluntary) begin
            ack_type_d = 4'd0;
            state_d    = S_GRANT_ACK;
          end
        end else if (io_acquire_valid) begin
          id_d      = io_acquire_bits_client_xact_id;
          blk_d     = acq_idx;
          builtin_d = io_acquire_bits_is_builtin_type;
          if (!io_acquire_bits_is_builtin_type) begin
            single_d = 1'b0;
            beat_d   = 3'd0;
            state_d  = S_GRANT_DATA;
          end else begin
            case (io_acquire_bits_a_type)
              3'd0: begin
                single_d = 1'b1;
                beat_d   = io_acquire_bits_addr_beat;
                state_d  = S_GRANT_DATA;
              end
              3'd1: begin
                single_d = 1'b0;
                beat_d   = 3'd0;
                state_d  = S_GRANT_DATA;
              end
              3'd2, 3'd3: begin
                wr_en      = 1'b1;
                wr_addr    = {acq_idx, io_acquire_bits_addr_beat};
                wr_data    = io_acquire_bits_data;
                wr_mask    = acq_mask;
                ack_type_d = 4'd2;
                state_d    = (io_acquire_bits_a_type == 3'd2) ? S_GRANT_ACK : S_PUT_COLLECT;
              end
              default: begin
                ack_type_d = 4'd2;
                state_d    = S_GRANT_ACK;
              end
            endcase
          end
        end
      end

      S_PUT_COLLECT: begin
        acq_rdy = 1'b1;
        if (io_acquire_valid) begin
          wr_en   = 1'b1;
          wr_addr = {blk_q, io_acquire_bits_addr_beat};
          wr_data = io_acquire_bits_data;
          wr_mask = acq_mask;
          if (io_acquire_bits_addr_beat == 3'd7) begin
            ack_type_d = 4'd2;
            state_d    = S_GRANT_ACK;
          end
        end
      end

      S_REL_COLLECT: begin
        rel_rdy = 1'b1;
        if (io_release_valid) begin
          wr_en   = 1'b1;
          wr_addr = {blk_q, io_release_bits_addr_beat};
          wr_data = io_release_bits_data;
          wr_mask = 8'hFF;
          if (io_release_bits_addr_beat == 3'd7) begin
            ack_type_d = 4'd0;
            state_d    = vol_q ? S_GRANT_ACK : S_IDLE;
          end
        end
      end

      S_GRANT_DATA: begin
        gnt_vld     = 1'b1;
        gnt_beat    = beat_q;
        gnt_id      = id_q;
        gnt_builtin = builtin_q;
        gnt_type    = single_q ? 4'd3 : (builtin_q ? 4'd4 : 4'd1);
        // No writes happen while granting, so the read stays stable under stall.
        gnt_data    = ram_q[{blk_q, beat_q}];
        if (io_grant_ready) begin
          if (single_q) begin
            state_d = S_IDLE;
          end else if (beat_q == 3'd7) begin
            state_d = builtin_q ? S_IDLE : S_WAIT_FINISH;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      S_GRANT_ACK: begin
        gnt_vld     = 1'b1;
        gnt_id      = id_q;
        gnt_builtin = 1'b1;
        gnt_type    = ack_type_q;
        if (io_grant_ready) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_FINISH: begin
        fin_rdy = 1'b1;
        if (io_finish_valid) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      blk_q      <= '0;
      beat_q     <= '0;
      builtin_q  <= 1'b0;
      single_q   <= 1'b0;
      vol_q      <= 1'b0;
      ack_type_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      blk_q      <= blk_d;
      beat_q     <= beat_d;
      builtin_q  <= builtin_d;
      single_q   <= single_d;
      vol_q      <= vol_d;
      ack_type_q <= ack_type_d;
    end
  end

  // RAM contents survive reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (wr_en && run) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) begin
          ram_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign io_acquire_ready              = acq_rdy & run;
  assign io_release_ready              = rel_rdy & run;
  assign io_finish_ready               = fin_rdy & run;
  assign io_grant_valid                = gnt_vld & run;
  assign io_grant_bits_addr_beat       = run ? gnt_beat : '0;
  assign io_grant_bits_client_xact_id  = run ? gnt_id : '0;
  assign io_grant_bits_manager_xact_id = 1'b0;
  assign io_grant_bits_is_builtin_type = gnt_builtin & run;
  assign io_grant_bits_g_type          = run ? gnt_type : '0;
  assign io_grant_bits_data            = run ? gnt_data : '0;
  assign io_grant_bits_manager_id      = MANAGER_ID & run;

  assign io_probe_valid           = 1'b0;
  assign io_probe_bits_addr_block = '0;
  assign io_probe_bits_p_type     = '0;

  logic unused_inputs;
  assign unused_inputs = ^{io_probe_ready, io_finish_bits_manager_xact_id,
                           io_finish_bits_manager_id,
                           io_acquire_bits_addr_block[25:IDX_W],
                           io_release_bits_addr_block[25:IDX_W],
                           io_acquire_bits_union[11:9], io_acquire_bits_union[0]};

endmodule

// File: tb/tb_tilelink_scratchpad_manager.sv
module tb_tilelink_scratchpad_manager;
  logic        clk = 1'b0;
  logic        reset;
  logic        io_acquire_ready, io_acquire_valid;
  logic [25:0] io_acquire_bits_addr_block;
  logic [1:0]  io_acquire_bits_client_xact_id;
  logic [2:0]  io_acquire_bits_addr_beat;
  logic        io_acquire_bits_is_builtin_type;
  logic [2:0]  io_acquire_bits_a_type;
  logic [11:0] io_acquire_bits_union;
  logic [63:0] io_acquire_bits_data;
  logic        io_probe_ready, io_probe_valid;
  logic [25:0] io_probe_bits_addr_block;
  logic [1:0]  io_probe_bits_p_type;
  logic        io_release_ready, io_release_valid;
  logic [2:0]  io_release_bits_addr_beat;
  logic [25:0] io_release_bits_addr_block;
  logic [1:0]  io_release_bits_client_xact_id;
  logic        io_release_bits_voluntary;
  logic [2:0]  io_release_bits_r_type;
  logic [63:0] io_release_bits_data;
  logic        io_grant_ready, io_grant_valid;
  logic [2:0]  io_grant_bits_addr_beat;
  logic [1:0]  io_grant_bits_client_xact_id;
  logic        io_grant_bits_manager_xact_id;
  logic        io_grant_bits_is_builtin_type;
  logic [3:0]  io_grant_bits_g_type;
  logic [63:0] io_grant_bits_data;
  logic        io_grant_bits_manager_id;
  logic        io_finish_ready, io_finish_valid;
  logic        io_finish_bits_manager_xact_id, io_finish_bits_manager_id;

  always #5 clk = ~clk;

  tilelink_scratchpad_manager #(.DEPTH_BLOCKS(16), .MANAGER_ID(1'b0)) dut (
    .clk(clk), .reset(reset),
    .io_acquire_ready(io_acquire_ready), .io_acquire_valid(io_acquire_valid),
    .io_acquire_bits_addr_block(io_acquire_bits_addr_block),
    .io_acquire_bits_client_xact_id(io_acquire_bits_client_xact_id),
    .io_acquire_bits_addr_beat(io_acquire_bits_addr_beat),
    .io_acquire_bits_is_builtin_type(io_acquire_bits_is_builtin_type),
    .io_acquire_bits_a_type(io_acquire_bits_a_type),
    .io_acquire_bits_union(io_acquire_bits_union),
    .io_acquire_bits_data(io_acquire_bits_data),
    .io_probe_ready(io_probe_ready), .io_probe_valid(io_probe_valid),
    .io_probe_bits_addr_block(io_probe_bits_addr_block),
    .io_probe_bits_p_type(io_probe_bits_p_type),
    .io_release_ready(io_release_ready), .io_release_valid(io_release_valid),
    .io_release_bits_addr_beat(io_release_bits_addr_beat),
    .io_release_bits_addr_block(io_release_bits_addr_block),
    .io_release_bits_client_xact_id(io_release_bits_client_xact_id),
    .io_release_bits_voluntary(io_release_bits_voluntary),
    .io_release_bits_r_type(io_release_bits_r_type),
    .io_release_bits_data(io_release_bits_data),
    .io_grant_ready(io_grant_ready), .io_grant_valid(io_grant_valid),
    .io_grant_bits_addr_beat(io_grant_bits_addr_beat),
    .io_grant_bits_client_xact_id(io_grant_bits_client_xact_id),
    .io_grant_bits_manager_xact_id(io_grant_bits_manager_xact_id),
    .io_grant_bits_is_builtin_type(io_grant_bits_is_builtin_type),
    .io_grant_bits_g_type(io_grant_bits_g_type),
    .io_grant_bits_data(io_grant_bits_data),
    .io_grant_bits_manager_id(io_grant_bits_manager_id),
    .io_finish_ready(io_finish_ready), .io_finish_valid(io_finish_valid),
    .io_finish_bits_manager_xact_id(io_finish_bits_manager_xact_id),
    .io_finish_bits_manager_id(io_finish_bits_manager_id)
  );

  int checks = 0;
  int failures = 0;

  // Reference memory: 16 blocks x 8 beats, indexed by (block mod 16)*8 + beat.
  logic [63:0] model_mem [0:127];
  bit          model_valid [0:127];
  int          written_q[$];

  function automatic int midx(input logic [25:0] blk, input logic [2:0] beat);
    return (int'(blk) % 16) * 8 + int'(beat);
  endfunction

  function automatic void model_write(input logic [25:0] blk, input logic [2:0] beat,
                                      input logic [63:0] data, input logic [7:0] mask);
    int i;
    i = midx(blk, beat);
    for (int b = 0; b < 8; b++) if (mask[b]) model_mem[i][8*b +: 8] = data[8*b +: 8];
    if (!model_valid[i]) begin
      model_valid[i] = 1'b1;
      written_q.push_back(i);
    end
  endfunction

  task automatic idle_inputs();
    io_acquire_valid = 0; io_acquire_bits_addr_block = 0; io_acquire_bits_client_xact_id = 0;
    io_acquire_bits_addr_beat = 0; io_acquire_bits_is_builtin_type = 0; io_acquire_bits_a_type = 0;
    io_acquire_bits_union = 0; io_acquire_bits_data = 0; io_probe_ready = 0;
    io_release_valid = 0; io_release_bits_addr_beat = 0; io_release_bits_addr_block = 0;
    io_release_bits_client_xact_id = 0; io_release_bits_voluntary = 0; io_release_bits_r_type = 0;
    io_release_bits_data = 0; io_grant_ready = 0; io_finish_valid = 0;
    io_finish_bits_manager_xact_id = 0; io_finish_bits_manager_id = 0;
  endtask

  task automatic set_acq(input bit builtin, input logic [2:0] typ, input logic [25:0] blk,
                         input logic [2:0] beat, input logic [7:0] mask,
                         input logic [63:0] data, input logic [1:0] id);
    io_acquire_valid = 1'b1;
    io_acquire_bits_is_builtin_type = builtin;
    io_acquire_bits_a_type = typ;
    io_acquire_bits_addr_block = blk;
    io_acquire_bits_addr_beat = beat;
    io_acquire_bits_union = {3'b000, mask, 1'b0};
    io_acquire_bits_data = data;
    io_acquire_bits_client_xact_id = id;
  endtask

  // All drivers are entered and left one time unit after a rising edge.
  task automatic send_acq(input bit builtin, input logic [2:0] typ, input logic [25:0] blk,
                          input logic [2:0] beat, input logic [7:0] mask,
                          input logic [63:0] data, input logic [1:0] id, output bit ok);
    ok = 1'b0;
    set_acq(builtin, typ, blk, beat, mask, data, id);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (io_acquire_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    io_acquire_valid = 1'b0;
  endtask

  task automatic send_rel(input logic [2:0] rtype, input bit vol, input logic [25:0] blk,
                          input logic [2:0] beat, input logic [63:0] data,
                          input logic [1:0] id, output bit ok);
    ok = 1'b0;
    io_release_valid = 1'b1;
    io_release_bits_r_type = rtype;
    io_release_bits_voluntary = vol;
    io_release_bits_addr_block = blk;
    io_release_bits_addr_beat = beat;
    io_release_bits_data = data;
    io_release_bits_client_xact_id = id;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (io_release_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    io_release_valid = 1'b0;
  endtask

  // Packet layout: {g_type[3:0], addr_beat[2:0], client_xact_id[1:0], is_builtin, data[63:0]}
  task automatic recv_grant(output bit ok, output logic [73:0] pkt);
    ok = 1'b0;
    pkt = '0;
    io_grant_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (io_grant_valid === 1'b1) begin
        ok = 1'b1;
        pkt = {io_grant_bits_g_type, io_grant_bits_addr_beat, io_grant_bits_client_xact_id,
               io_grant_bits_is_builtin_type, io_grant_bits_data};
        break;
      end
    end
    @(posedge clk); #1;
    io_grant_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({io_acquire_ready, io_release_ready, io_finish_ready, io_grant_valid, io_probe_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshake: got %b expected 00000",
               {io_acquire_ready, io_release_ready, io_finish_ready, io_grant_valid, io_probe_valid});
    end
    checks++;
    if ({io_grant_bits_g_type, io_grant_bits_addr_beat, io_grant_bits_client_xact_id,
         io_grant_bits_is_builtin_type, io_grant_bits_data, io_grant_bits_manager_id,
         io_grant_bits_manager_xact_id} !== 76'd0) begin
      failures++;
      $display("FAIL reset_grant_bits: got g_type=%0d data=%h expected zero", io_grant_bits_g_type, io_grant_bits_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({io_acquire_ready, io_release_ready, io_finish_ready, io_grant_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL idle_readies: got %b expected 1100",
               {io_acquire_ready, io_release_ready, io_finish_ready, io_grant_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_put_get();
    bit ok; logic [73:0] pkt, exp;
    send_acq(1, 3'd2, 26'd5, 3'd2, 8'hFF, 64'h1122334455667788, 2'd1, ok);
    model_write(26'd5, 3'd2, 64'h1122334455667788, 8'hFF);
    recv_grant(ok, pkt);
    exp = {4'd2, 3'd0, 2'd1, 1'b1, 64'd0};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL put_ack: got %h expected %h", pkt, exp); end
    send_acq(1, 3'd0, 26'd5, 3'd2, 8'h00, 64'd0, 2'd2, ok);
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd2, 2'd2, 1'b1, 64'h1122334455667788};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL get_data: got %h expected %h", pkt, exp); end
  endtask

  task automatic test_putblock_getblock();
    bit ok, all_ok, stalled; logic [73:0] pkt, exp, cur, snap;
    int idx;
    all_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      send_acq(1, 3'd3, 26'd3, 3'(b), 8'hFF, 64'(b * 32'h0101), 2'd0, ok);
      all_ok &= ok;
      model_write(26'd3, 3'(b), 64'(b * 32'h0101), 8'hFF);
    end
    recv_grant(ok, pkt);
    exp = {4'd2, 3'd0, 2'd0, 1'b1, 64'd0};
    checks++;
    if (!all_ok || !ok || pkt !== exp) begin failures++; $display("FAIL putblock_ack: got %h expected %h", pkt, exp); end
    send_acq(1, 3'd1, 26'd3, 3'd0, 8'h00, 64'd0, 2'd1, ok);
    idx = 0; stalled = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      io_grant_ready = cyc[0];
      @(negedge clk);
      if (io_grant_valid === 1'b1) begin
        cur = {io_grant_bits_g_type, io_grant_bits_addr_beat, io_grant_bits_client_xact_id,
               io_grant_bits_is_builtin_type, io_grant_bits_data};
        if (stalled) begin
          checks++;
          if (cur !== snap) begin failures++; $display("FAIL stall_stable: got %h expected %h", cur, snap); end
        end
        if (io_grant_ready) begin
          exp = {4'd4, 3'(idx), 2'd1, 1'b1, model_mem[midx(26'd3, 3'(idx))]};
          checks++;
          if (cur !== exp) begin failures++; $display("FAIL getblock_beat%0d: got %h expected %h", idx, cur, exp); end
          idx++;
          stalled = 1'b0;
        end else begin
          snap = cur;
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    io_grant_ready = 1'b0;
    checks++;
    if (idx != 8) begin failures++; $display("FAIL getblock_count: got %0d expected 8", idx); end
    @(negedge clk);
    checks++;
    if ({io_acquire_ready, io_grant_valid} !== 2'b10) begin
      failures++; $display("FAIL getblock_idle: got %b expected 10", {io_acquire_ready, io_grant_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mask();
    bit ok; logic [73:0] pkt, exp;
    send_acq(1, 3'd2, 26'd7, 3'd1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, ok);
    model_write(26'd7, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    recv_grant(ok, pkt);
    send_acq(1, 3'd2, 26'd7, 3'd1, 8'h0F, 64'd0, 2'd3, ok);
    model_write(26'd7, 3'd1, 64'd0, 8'h0F);
    recv_grant(ok, pkt);
    exp = {4'd2, 3'd0, 2'd3, 1'b1, 64'd0};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL mask_ack: got %h expected %h", pkt, exp); end
    send_acq(1, 3'd0, 26'd7, 3'd1, 8'h00, 64'd0, 2'd0, ok);
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd1, 2'd0, 1'b1, 64'hFFFF_FFFF_0000_0000};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL mask_get: got %h expected %h", pkt, exp); end
  endtask

  task automatic test_nonbuiltin();
    bit ok, all_ok, stuck; logic [73:0] pkt, exp;
    // Block 19 aliases block 3 in a 16-block scratchpad.
    send_acq(0, 3'd0, 26'd19, 3'd5, 8'h00, 64'd0, 2'd3, ok);
    all_ok = ok;
    for (int i = 0; i < 8; i++) begin
      recv_grant(ok, pkt);
      exp = {4'd1, 3'(i), 2'd3, 1'b0, model_mem[midx(26'd3, 3'(i))]};
      checks++;
      if (!all_ok || !ok || pkt !== exp) begin failures++; $display("FAIL nonbuiltin_beat%0d: got %h expected %h", i, pkt, exp); end
    end
    set_acq(1, 3'd0, 26'd5, 3'd2, 8'h00, 64'd0, 2'd0);
    stuck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({io_acquire_ready, io_release_ready, io_finish_ready} !== 3'b001) stuck = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!stuck) begin failures++; $display("FAIL wait_finish_readies: got %b expected 001",
                                           {io_acquire_ready, io_release_ready, io_finish_ready}); end
    io_finish_valid = 1'b1;
    @(posedge clk); #1;
    io_finish_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (io_acquire_ready !== 1'b1) begin failures++; $display("FAIL get_after_finish: got ready=%b expected 1", io_acquire_ready); end
    @(posedge clk); #1;
    io_acquire_valid = 1'b0;
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd2, 2'd0, 1'b1, model_mem[midx(26'd5, 3'd2)]};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL get_after_finish_data: got %h expected %h", pkt, exp); end
  endtask

  task automatic test_release_priority();
    bit ok; logic [73:0] pkt, exp;
    set_acq(1, 3'd0, 26'd7, 3'd1, 8'h00, 64'd0, 2'd2);
    io_release_valid = 1'b1; io_release_bits_r_type = 3'd3; io_release_bits_voluntary = 1'b1;
    io_release_bits_client_xact_id = 2'd3; io_release_bits_addr_block = 26'd7;
    io_release_bits_addr_beat = 3'd1; io_release_bits_data = 64'hDEAD;
    @(negedge clk);
    checks++;
    if ({io_acquire_ready, io_release_ready} !== 2'b01) begin
      failures++; $display("FAIL release_priority: got %b expected 01", {io_acquire_ready, io_release_ready});
    end
    @(posedge clk); #1;
    io_release_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({io_acquire_ready, io_grant_valid} !== 2'b01) begin
      failures++; $display("FAIL release_ack_pending: got %b expected 01", {io_acquire_ready, io_grant_valid});
    end
    @(posedge clk); #1;
    recv_grant(ok, pkt);
    exp = {4'd0, 3'd0, 2'd3, 1'b1, 64'd0};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL release_ack: got %h expected %h", pkt, exp); end
    send_acq(1, 3'd0, 26'd7, 3'd1, 8'h00, 64'd0, 2'd2, ok);
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd1, 2'd2, 1'b1, model_mem[midx(26'd7, 3'd1)]};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL acquire_after_release: got %h expected %h", pkt, exp); end
  endtask

  task automatic test_release_data();
    bit ok, quiet; logic [73:0] pkt, exp; logic [63:0] d;
    for (int b = 0; b < 8; b++) begin
      d = {$urandom, $urandom};
      send_rel(3'd0, 1'b1, 26'd9, 3'(b), d, 2'd1, ok);
      model_write(26'd9, 3'(b), d, 8'hFF);
    end
    recv_grant(ok, pkt);
    exp = {4'd0, 3'd0, 2'd1, 1'b1, 64'd0};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL release_data_ack: got %h expected %h", pkt, exp); end
    for (int b = 0; b < 8; b++) begin
      d = {$urandom, $urandom};
      send_rel(3'd2, 1'b0, 26'd10, 3'(b), d, 2'd2, ok);
      model_write(26'd10, 3'(b), d, 8'hFF);
    end
    send_rel(3'd5, 1'b0, 26'd9, 3'd0, 64'hBAD0_BAD0_BAD0_BAD0, 2'd0, ok);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ({io_grant_valid, io_acquire_ready} !== 2'b01) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!quiet) begin failures++; $display("FAIL nonvoluntary_no_grant: got %b expected 01", {io_grant_valid, io_acquire_ready}); end
    send_acq(1, 3'd0, 26'd10, 3'd6, 8'h00, 64'd0, 2'd1, ok);
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd6, 2'd1, 1'b1, model_mem[midx(26'd10, 3'd6)]};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL release_written: got %h expected %h", pkt, exp); end
    send_acq(1, 3'd0, 26'd9, 3'd0, 8'h00, 64'd0, 2'd0, ok);
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd0, 2'd0, 1'b1, model_mem[midx(26'd9, 3'd0)]};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL dataless_release_nowrite: got %h expected %h", pkt, exp); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [73:0] pkt, exp;
    send_acq(1, 3'd1, 26'd3, 3'd0, 8'h00, 64'd0, 2'd0, ok);
    for (int i = 0; i < 4; i++) recv_grant(ok, pkt);
    @(negedge clk);
    checks++;
    if ({io_grant_valid, io_grant_bits_addr_beat} !== 4'b1100) begin
      failures++; $display("FAIL before_reset_beat4: got %b expected 1100", {io_grant_valid, io_grant_bits_addr_beat});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({io_grant_valid, io_acquire_ready, io_release_ready} !== 3'b011) begin
      failures++; $display("FAIL after_reset_idle: got %b expected 011", {io_grant_valid, io_acquire_ready, io_release_ready});
    end
    @(posedge clk); #1;
    send_acq(1, 3'd0, 26'd3, 3'd5, 8'h00, 64'd0, 2'd1, ok);
    recv_grant(ok, pkt);
    exp = {4'd3, 3'd5, 2'd1, 1'b1, model_mem[midx(26'd3, 3'd5)]};
    checks++;
    if (!ok || pkt !== exp) begin failures++; $display("FAIL get_after_reset: got %h expected %h", pkt, exp); end
  endtask

  task automatic test_random();
    bit ok; logic [73:0] pkt, exp;
    logic [25:0] blk; logic [2:0] beat; logic [63:0] d; logic [7:0] mask; logic [1:0] id;
    int op, i;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      id = 2'($urandom_range(0, 3));
      if (op == 0 || written_q.size() == 0) begin
        blk = 26'($urandom_range(0, 63));
        beat = 3'($urandom_range(0, 7));
        d = {$urandom, $urandom};
        mask = model_valid[midx(blk, beat)] ? 8'($urandom_range(0, 255)) : 8'hFF;
        send_acq(1, 3'd2, blk, beat, mask, d, id, ok);
        model_write(blk, beat, d, mask);
        recv_grant(ok, pkt);
        exp = {4'd2, 3'd0, id, 1'b1, 64'd0};
        checks++;
        if (!ok || pkt !== exp) begin failures++; $display("FAIL rand_put_ack it%0d: got %h expected %h", it, pkt, exp); end
      end else if (op == 1) begin
        i = written_q[$urandom_range(0, written_q.size() - 1)];
        blk = 26'(i / 8 + 16 * int'($urandom_range(0, 3)));
        beat = 3'(i % 8);
        send_acq(1, 3'd0, blk, beat, 8'h00, 64'd0, id, ok);
        recv_grant(ok, pkt);
        exp = {4'd3, beat, id, 1'b1, model_mem[i]};
        checks++;
        if (!ok || pkt !== exp) begin failures++; $display("FAIL rand_get it%0d: got %h expected %h", it, pkt, exp); end
      end else begin
        send_rel(3'($urandom_range(3, 7)), 1'b1, 26'($urandom_range(0, 15)), 3'd0, {$urandom, $urandom}, id, ok);
        recv_grant(ok, pkt);
        exp = {4'd0, 3'd0, id, 1'b1, 64'd0};
        checks++;
        if (!ok || pkt !== exp) begin failures++; $display("FAIL rand_rel_ack it%0d: got %h expected %h", it, pkt, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_putblock_getblock();
    test_mask();
    test_nonbuiltin();
    test_release_priority();
    test_release_data();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/tilelink_scratchpad_manager.md
Name: tilelink_scratchpad_manager

Overview:
- Manager-side endpoint for the client TileLink channel set (acquire/probe/release/grant/finish) at the same field widths.
- Terminates the client's outer port and serves all traffic from an on-chip block-organised scratchpad RAM.
- Sits at the far end of the client enqueuer path; used as a bring-up memory and as a protocol responder for verification.
- One transaction at a time, fully handshaked, no probes issued.

Parameters:
DEPTH_BLOCKS, 16, number of 8-beat x 64-bit blocks in the scratchpad (power of 2, 2..256)
MANAGER_ID, 0, value driven on grant manager_id (1 bit)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
io_acquire_ready  out  1  acquire accept
io_acquire_valid  in  1  acquire valid
io_acquire_bits_addr_block  in  26  block address; index = low log2(DEPTH_BLOCKS) bits
io_acquire_bits_client_xact_id  in  2  client transaction id
io_acquire_bits_addr_beat  in  3  beat within block
io_acquire_bits_is_builtin_type  in  1  1 = uncached built-in type
io_acquire_bits_a_type  in  3  0 Get, 1 GetBlock, 2 Put, 3 PutBlock, others unsupported
io_acquire_bits_union  in  12  [8:1] byte write mask for Put/PutBlock
io_acquire_bits_data  in  64  write data
io_probe_ready  in  1  ignored
io_probe_valid  out  1  constant 0
io_probe_bits_addr_block  out  26  constant 0
io_probe_bits_p_type  out  2  constant 0
io_release_ready  out  1  release accept
io_release_valid  in  1  release valid
io_release_bits_addr_beat  in  3  beat
io_release_bits_addr_block  in  26  block address
io_release_bits_client_xact_id  in  2  id
io_release_bits_voluntary  in  1  1 = voluntary, needs ack
io_release_bits_r_type  in  3  0..2 data-bearing (8 beats), others single beat, no data
io_release_bits_data  in  64  data
io_grant_ready  in  1  grant accept
io_grant_valid  out  1  grant valid
io_grant_bits_addr_beat  out  3  beat
io_grant_bits_client_xact_id  out  2  echoed id
io_grant_bits_manager_xact_id  out  1  constant 0
io_grant_bits_is_builtin_type  out  1  echoed is_builtin_type (1 for release acks)
io_grant_bits_g_type  out  4  grant type
io_grant_bits_data  out  64  read data
io_grant_bits_manager_id  out  1  MANAGER_ID
io_finish_ready  out  1  finish accept
io_finish_valid  in  1  finish valid
io_finish_bits_manager_xact_id  in  1  ignored
io_finish_bits_manager_id  in  1  ignored

Behaviour:
- Reset (sync, high): state IDLE; every valid/ready output 0; grant bits 0; beat counter 0. RAM contents are not reset. Reset mid-transaction abandons it; no grant follows.
- States: IDLE, PUT_COLLECT, REL_COLLECT, GRANT_DATA, GRANT_ACK, WAIT_FINISH.
- IDLE:
  - acquire_ready = 1 and release_ready = 1; finish_ready = 0.
  - If acquire_valid and release_valid are both high, release wins; acquire_ready drops that cycle.
- Get (builtin, type 0): on fire, latch id, block and beat. Next cycle: grant_valid = 1, g_type 3, data = RAM[block][beat]. When grant fires -> IDLE.
- GetBlock (type 1) and any non-builtin acquire:
  - Grant beats 0..7 in order, one per cycle while grant_ready stays high.
  - Builtin: g_type 4. Non-builtin: g_type 1, is_builtin 0.
  - After the beat-7 fire: non-builtin -> WAIT_FINISH; builtin -> IDLE.
- Put (type 2): on fire, write RAM[block][beat] with byte mask union[8:1] -> GRANT_ACK.
- PutBlock (type 3): first beat written on fire -> PUT_COLLECT.
  - PUT_COLLECT accepts the remaining beats with acquire_ready = 1.
  - Each beat is written at its own addr_beat with its own mask.
  - Exit to GRANT_ACK after the beat with addr_beat = 7.
- Unsupported builtin types 4..7: no RAM access -> GRANT_ACK.
- GRANT_ACK: grant_valid = 1, g_type 2 (putAck), addr_beat 0, data 0. Grant fire -> IDLE.
- Release:
  - Data-bearing r_type (0..2): first beat written on fire -> REL_COLLECT, which collects and writes beats until the beat with addr_beat = 7.
  - Other r_types: no write.
  - On completion, voluntary = 1 -> GRANT_ACK-like state with g_type 0, is_builtin 1, echoed id; voluntary = 0 -> IDLE, no grant.
- WAIT_FINISH: finish_ready = 1, all other readies 0. Finish fire -> IDLE.
- Grant bits hold stable while grant_valid = 1 and grant_ready = 0.
- Read/write ordering: a write completed in one cycle is visible to a Get accepted in the next cycle.
- Index wrap: addr_block values differing only above the index bits alias to the same block.

Test Plan:
- Put block 5 beat 2, data 0x1122334455667788, mask 0xFF; then Get the same -> putAck (g_type 2); then Get grant g_type 3 with data 0x1122334455667788, id echoed.
- PutBlock block 3, beats 0..7 data = beat*0x0101, full mask; then GetBlock with grant_ready toggled every other cycle -> 8 grants, g_type 4, beats 0..7 in order, data matches, bits stable while stalled.
- Put with mask 0x0F over 0xFFFF_FFFF_FFFF_FFFF, data 0 -> Get returns 0xFFFF_FFFF_0000_0000.
- Non-builtin acquire -> 8 grants g_type 1, is_builtin 0; acquire_ready stays 0 until finish fires, then an immediate Get is accepted.
- Simultaneous acquire and voluntary release (r_type 3) -> release accepted first, voluntary-ack grant g_type 0; acquire served next.
- Reset asserted during the beat-4 GetBlock grant -> next cycle grant_valid 0, state IDLE; a subsequent Get still returns the previously written data.
